// File: rtl/cla_word_sequencer.sv
// Multi-precision add/subtract over one shared 16-bit CLA, LSW first; out_valid rises WORDS cycles after accept.
// Backpressure: result is held in DONE until out_ready; in_ready is high only in IDLE, commands are never queued.
module CLA16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout,
    output logic        PG,
    output logic        GG
);
    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  bp;
    logic [3:0]  bg;
    logic [4:0]  bc;
    logic [16:0] c;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bp[k] = &p[4*k +: 4];
            bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Second-level lookahead across the four 4-bit groups
    assign bc[0] = Cin;
    assign bc[1] = bg[0] | (bp[0] & Cin);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & Cin);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0]) | (bp[2] & bp[1] & bp[0] & Cin);
    assign bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) | (bp[3] & bp[2] & bp[1] & bg[0])
                 | (bp[3] & bp[2] & bp[1] & bp[0] & Cin);

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = bc[k];
            for (int j = 0; j < 3; j++)
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
        end
        c[16] = bc[4];
    end

    assign S    = p ^ c[15:0];
    assign Cout = bc[4];
    assign PG   = &bp;
    assign GG   = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) | (bp[3] & bp[2] & bp[1] & bg[0]);
endmodule

module cla_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   A,
    input  logic [16*WORDS-1:0]   B,
    input  logic                  Cin,
    input  logic                  Sub,
    output logic [16*WORDS-1:0]   S,
    output logic                  Cout,
    output logic                  Ovf,
    output logic                  Zero,
    output logic                  AllProp,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    beff_reg;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            prop;
    logic            last;
    logic [15:0]     cla_s;
    logic            cla_cout;
    logic            cla_pg;
    logic            cla_gg;
    logic            unused_gg;

    assign last      = (idx == IW'(WORDS - 1));
    assign unused_gg = cla_gg;

    CLA16bit u_cla (
        .A    (a_reg[{idx, 4'b0000} +: 16]),
        .B    (beff_reg[{idx, 4'b0000} +: 16]),
        .Cin  (carry),
        .S    (cla_s),
        .Cout (cla_cout),
        .PG   (cla_pg),
        .GG   (cla_gg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            beff_reg <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            prop     <= 1'b0;
            S        <= '0;
            Cout     <= 1'b0;
            Ovf      <= 1'b0;
            AllProp  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg    <= A;
                    beff_reg <= B ^ {W{Sub}};
                    carry    <= Cin ^ Sub;
                    idx      <= '0;
                    prop     <= 1'b1;
                end
                RUN: begin
                    S[{idx, 4'b0000} +: 16] <= cla_s;
                    carry <= cla_cout;
                    prop  <= prop & cla_pg;
                    if (last) begin
                        Cout    <= cla_cout;
                        Ovf     <= (a_reg[W-1] == beff_reg[W-1]) & (cla_s[15] != a_reg[W-1]);
                        AllProp <= prop & cla_pg;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Zero = ~|S;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Randomized and directed bench for cla_word_sequencer against a plain wide-arithmetic reference.
module tb_cla_word_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic [W-1:0] S;
    logic         Cout, Ovf, Zero, AllProp, out_valid;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    cla_word_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .S(S), .Cout(Cout), .Ovf(Ovf),
        .Zero(Zero), .AllProp(AllProp), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[16*i +: 16] = 16'hFFFF;
                1:       v[16*i +: 16] = 16'h0000;
                default: v[16*i +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                                input logic eo, input logic ep);
        check({tag, "_vld"},  W'(out_valid), W'(1));
        check({tag, "_S"},    S, es);
        check({tag, "_cout"}, W'(Cout), W'(ec));
        check({tag, "_ovf"},  W'(Ovf), W'(eo));
        check({tag, "_zero"}, W'(Zero), W'(es == '0));
        check({tag, "_prop"}, W'(AllProp), W'(ep));
    endtask

    // hold: extra DONE cycles with out_ready low; junk: wiggle inputs with in_valid=1 while busy
    task automatic do_cmd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int hold, input bit junk,
                          input bit early);
        logic [W-1:0] beff, es;
        logic [W:0]   full;
        logic         ec, eo, ep;
        int           lat, waitc;
        bit           busy_rdy;
        beff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, cin ^ sub};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (a[W-1] == beff[W-1]) && (es[W-1] != a[W-1]);
        ep   = &(a ^ beff);

        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) check({tag, "_rdy_wait"}, W'(in_ready), W'(1));
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        out_ready = early;
        @(posedge clk);
        @(negedge clk);
        in_valid = junk;
        A = rand_word(); B = rand_word(); Cin = 1'($urandom); Sub = 1'($urandom);
        lat = 0;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, W'(lat), W'(WORDS));
        check({tag, "_busy_rdy"}, W'(busy_rdy | in_ready), W'(0));
        check_result(tag, es, ec, eo, ep);
        for (int h = 0; h < hold && !early; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_result({tag, "_hold"}, es, ec, eo, ep);
            check({tag, "_hold_rdy"}, W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld_fall"}, W'(out_valid), W'(0));
        check({tag, "_rdy_rise"}, W'(in_ready), W'(1));
        out_ready = early;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("rst_rdy",  W'(in_ready), W'(1));
        check("rst_vld",  W'(out_valid), W'(0));
        check("rst_S",    S, '0);
        check("rst_zero", W'(Zero), W'(1));
        check("rst_flags", W'({Cout, Ovf, AllProp}), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_cmd("t1",   64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_cmd("t2a",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_cmd("t2b",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        do_cmd("t3a",  64'h5, 64'h7, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_cmd("t3b",  64'h7, 64'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_cmd("t4",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_cmd("t5",   64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        do_cmd("t5b",  64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Reset two edges after accept: everything clears asynchronously, no result surfaces
        @(negedge clk);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", W'(in_ready), W'(1));
        check("mid_rst_vld", W'(out_valid), W'(0));
        check("mid_rst_S",   S, '0);
        check("mid_rst_flags", W'({Cout, Ovf, AllProp}), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_novld", W'(out_valid), W'(0));
        end
        rst_n = 1'b1;
        do_cmd("post_rst", 64'h1, 64'h2, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            bit early;
            early = ($urandom_range(0, 3) == 0);
            do_cmd("rnd", rand_word(), rand_word(), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom), early);
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-precision add/subtract controller built around one `CLA16bit` instance.
- Accepts wide operands (16×WORDS bits) over a valid/ready handshake and streams them through the 16-bit adder one word per cycle, LSW first.
- Chains the carry through a register and presents the full result with flags on an output handshake.
- Sits between the team's datapath sequencers and the shared 16-bit CLA, giving wide arithmetic without a wide adder.

## Interface
Parameters:
- WORDS, 4, number of 16-bit words per operand (operand width W = 16×WORDS); legal range 2–16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/command valid.
- in_ready  out  1  block can accept a command (IDLE only).
- A  in  W  operand A.
- B  in  W  operand B.
- Cin  in  1  carry-in to word 0.
- Sub  in  1  1 = compute A − B (B inverted, carry-in = Cin XOR 1).
- S  out  W  result.
- Cout  out  1  carry out of the MSW (for Sub: 1 = no borrow).
- Ovf  out  1  signed overflow of the W-bit result.
- Zero  out  1  S == 0.
- AllProp  out  1  AND of the CLA PG output over all words.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

## Operation
- One internal `CLA16bit`, port A = word idx of latched A, port B = word idx of latched effective B, port Cin = carry register.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1, the block:
  - latches A, B XOR {W{Sub}}, and Sub;
  - sets carry = Cin XOR Sub, idx = 0, prop = 1;
  - moves to RUN.
- RUN: each cycle, S[16·idx +: 16] ← CLA S, carry ← CLA Cout, prop ← prop & CLA PG, idx ← idx+1.
  - On the edge where idx = WORDS−1, the block moves to DONE instead of incrementing.
  - At the same edge it registers the flags:
    - Cout = CLA Cout.
    - Ovf = (A_msb == Beff_msb) & (S_msb != A_msb), where S_msb is the CLA S[15] of the final word.
    - AllProp = prop & PG.
- DONE: out_valid=1. S, Cout, Ovf, Zero, AllProp are held stable until out_ready=1, then the block returns to IDLE.
- Zero is combinational from the registered S (S == 0) and is valid whenever out_valid=1.
- A, B, Cin and Sub are don't-care outside the accept cycle. Changing them during RUN has no effect.
- in_valid outside IDLE is ignored and the command is not queued.
- idx width is ceil(log2(WORDS)) and never wraps past WORDS−1.
- GG from the CLA is not used.

## Timing
- Reset (async assert, any state): state=IDLE, idx=0, carry=0, S=0, Cout=0, Ovf=0, AllProp=0, out_valid=0, in_ready=1.
  - Zero then reads 1 from the cleared S. This is allowed because out_valid=0.
  - Reset mid-RUN or mid-DONE discards the command. No partial result is ever flagged valid.
- Release is synchronous to clk. The first accept is possible on the first edge after rst_n rises.
- Accept edge = edge with in_valid & in_ready.
- out_valid rises WORDS edges after the accept edge.
- Word k of S is written on edge k+1 after accept.
- Handshake timing:
  - DONE + out_ready: out_valid falls on that edge.
  - in_ready rises on that same edge; the earliest next accept is the following edge.
  - Minimum command interval is therefore WORDS+2 cycles.
- out_ready may be held high continuously. DONE then lasts exactly one cycle.
- S bits are not cleared between commands. Upper words retain old values until overwritten during RUN, so consumers must sample S only when out_valid=1.

## Test plan
All scenarios use WORDS=4, W=64.
1. A=0x0000_0000_0000_FFFF, B=0x1, Cin=0, Sub=0:
   - S=0x0000_0000_0001_0000, Cout=0, Ovf=0, Zero=0.
   - out_valid exactly 4 edges after accept.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Cin=0:
   - S=0, Cout=1, Zero=1, Ovf=0.
   - Repeat with B=0, Cin=1: same result.
3. Sub=1, A=0x5, B=0x7, Cin=0:
   - S=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0.
   - Then A=0x7, B=0x5: S=0x2, Cout=1.
4. A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Sub=0:
   - S=0x8000_0000_0000_0000, Ovf=1, Cout=0.
5. Hold and back-pressure check:
   - Stimulus: A=0x5555_5555_5555_5555, B=0xAAAA_AAAA_AAAA_AAAA, Cin=0, out_ready low for 3 cycles after out_valid.
   - S=0xFFFF_FFFF_FFFF_FFFF and AllProp=1, all outputs stable while held.
   - A new in_valid during RUN/DONE is ignored; in_ready=0 throughout.
   - Second command accepted only after the out_ready edge.
6. Reset mid-operation:
   - Stimulus: start command 1, assert rst_n=0 two edges after accept.
   - Outputs zero and in_ready=1 immediately, without waiting for a clock edge.
   - No out_valid pulse occurs.
   - After release, a fresh command (A=1, B=2) returns S=3.
